data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port synchronous data RAM between the core data port and a
//  loader/debug port (program load, memory inspection). Grants one requester per
//  cycle, routes 1-cycle-latency read data back to the issuing port and bounds
//  consecutive grants so neither port starves. Sits between core RAM pins and RAM.
// PARAMETERS
//  DATA_WIDTH  32  width of RAM word and both wdata/rdata buses
//  ADDR_WIDTH  10  RAM word-address width
//  MAX_BURST   4   max consecutive grants to one port while the other is requesting
// PORTS
//  CLK          in   1           clock, rising edge
//  RESET_N      in   1           asynchronous, active-low reset
//  CORE_REQ     in   1           core requests access this cycle
//  CORE_WE      in   1           1 = write, 0 = read
//  CORE_ADDR    in   ADDR_WIDTH  core word address
//  CORE_WDATA   in   DATA_WIDTH  core write data
//  CORE_GNT     out  1           core access accepted this cycle (comb.)
//  CORE_STALL   out  1           CORE_REQ & ~CORE_GNT; freezes core PC
//  CORE_RVALID  out  1           CORE_RDATA valid (1 cycle after granted read)
//  CORE_RDATA   out  DATA_WIDTH  read data to core
//  LDR_REQ      in   1           loader requests access
//  LDR_WE       in   1           1 = write, 0 = read
//  LDR_ADDR     in   ADDR_WIDTH  loader word address
//  LDR_WDATA    in   DATA_WIDTH  loader write data
//  LDR_GNT      out  1           loader access accepted this cycle (comb.)
//  LDR_RVALID   out  1           LDR_RDATA valid
//  LDR_RDATA    out  DATA_WIDTH  read data to loader
//  RAM_ADDR     out  ADDR_WIDTH  RAM address (granted port's address, else 0)
//  RAM_WDATA    out  DATA_WIDTH  RAM write data
//  RAM_WE       out  1           RAM write enable = granted & WE
//  RAM_Q        in   DATA_WIDTH  RAM read data, valid 1 cycle after address
// BEHAVIOUR
//  - Reset: owner=NONE, burst count=0, rr pointer=CORE, CORE_RVALID=LDR_RVALID=0,
//    RDATA outputs 0; GNT/RAM_WE 0 since no requests are registered.
//  - Per cycle at most one GNT; GNT only when the matching REQ is high.
//  - FSM on registered owner (OWN_NONE, OWN_CORE, OWN_LDR):
//    NONE: grant per priority rule; next owner = granted port, count=1.
//    CORE/LDR: if owner still requests and (other idle or count<MAX_BURST) keep
//    owner, count+1 (saturate). Elif other requests: switch, count=1.
//    Elif nobody requests: go NONE, count=0.
//  - Priority rule when both request from NONE: fixed CORE first (see CONFIG).
//  - Read return: granted read latches {port} in a 1-bit tag + valid flop; next
//    cycle the tagged port's RVALID=1 and its RDATA=RAM_Q; other RDATA holds.
//  - Write: RAM_WE same cycle as GNT; no RVALID generated.
//  - Back-to-back reads across ports: each return routed by its own tag.
//  - MAX_BURST=1 gives strict alternation under contention.
//  - Reset mid-read: pending return dropped, no RVALID after reset release.
// CONFIGURATION
//  DATA_MEM_ARB_RR_EN defined: tie-break from NONE uses rr pointer (last-served
//    port loses); pointer updated on every grant.
//  Undefined: tie-break from NONE always CORE; rr pointer logic absent.
//  Burst limit applies in both builds.
// STRUCTURE
//  Package mem_arb_pkg: owner_e enum {OWN_NONE, OWN_CORE, OWN_LDR}, port_e
//  {PORT_CORE, PORT_LDR}, localparam for burst-count width $clog2(MAX_BURST+1).
//  Sub-module arb_burst_counter: load-1 / increment-saturate / clear counter with
//  limit_reached output; FSM and return tag stay in the top module.
// TESTING
//  1 Core read only, addr 0x010, RAM_Q=0xDEADBEEF -> GNT same cycle, CORE_RVALID
//    and CORE_RDATA=0xDEADBEEF next cycle, LDR_RVALID stays 0.
//  2 Both REQ continuously, MAX_BURST=4, default build -> grants CORE x4, LDR x4,
//    repeating; CORE_STALL high exactly in the LDR cycles.
//  3 Both REQ from NONE, DATA_MEM_ARB_RR_EN, last grant CORE -> LDR granted first.
//  4 LDR write 0x0000_0013 @0x000 then core read @0x000 next cycle -> RAM_WE
//    1 cycle, core reads 0x0000_0013.
//  5 Core read granted, RESET_N low next cycle -> no CORE_RVALID, all outputs at
//    reset values, owner NONE after release.
//  6 Interleaved reads CORE@1, LDR@2 on alternate cycles -> each RVALID only on
//    own port with correct RAM_Q.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and sizing helpers for the data RAM arbiter.
//   owner_e : registered owner of the RAM port (none / core / loader)
//   port_e  : requester identity, also used as the 1-bit read-return tag
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_LDR  = 2'd2
    } owner_e;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_LDR  = 1'b1
    } port_e;

    localparam int MAX_BURST_DEFAULT = 4;
    localparam int BURST_CNT_W       = $clog2(MAX_BURST_DEFAULT + 1);

    // Counter width able to hold 0..max_burst.
    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// arb_burst_counter
//   Counts consecutive grants to the current RAM owner.
//   Ports:
//     CLK, RESET_N   clock / asynchronous active-low reset
//     load_one       start a new burst (count = 1)
//     incr           owner kept: count + 1, saturating at MAX_BURST
//     clear          no owner: count = 0
//     limit_reached  count has reached MAX_BURST
module arb_burst_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT,
    parameter int CNT_W     = burst_cnt_w(MAX_BURST)
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic load_one,
    input  logic incr,
    input  logic clear,
    output logic limit_reached
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load_one) begin
            count <= CNT_W'(1);
        end else if (incr && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign limit_reached = (count >= LIMIT);

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port synchronous data RAM between the core data port and
//   the loader/debug port. One grant per cycle, grant is combinational on the
//   request; read data (1-cycle RAM latency) is steered back by a 1-bit tag.
//   A port keeps the RAM for at most MAX_BURST consecutive grants while the
//   other port is waiting.
//   Build option: DATA_MEM_ARB_RR_EN -- when defined, a tie from the idle state
//   goes to the port that was NOT served last; otherwise the core wins ties.
//   Ports:
//     CLK, RESET_N                  clock / asynchronous active-low reset
//     CORE_REQ/WE/ADDR/WDATA        core request
//     CORE_GNT, CORE_STALL          core accepted / core must hold
//     CORE_RVALID, CORE_RDATA       core read return
//     LDR_REQ/WE/ADDR/WDATA         loader request
//     LDR_GNT                       loader accepted
//     LDR_RVALID, LDR_RDATA         loader read return
//     RAM_ADDR/WDATA/WE, RAM_Q      RAM interface
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  CORE_REQ,
    input  logic                  CORE_WE,
    input  logic [ADDR_WIDTH-1:0] CORE_ADDR,
    input  logic [DATA_WIDTH-1:0] CORE_WDATA,
    output logic                  CORE_GNT,
    output logic                  CORE_STALL,
    output logic                  CORE_RVALID,
    output logic [DATA_WIDTH-1:0] CORE_RDATA,
    input  logic                  LDR_REQ,
    input  logic                  LDR_WE,
    input  logic [ADDR_WIDTH-1:0] LDR_ADDR,
    input  logic [DATA_WIDTH-1:0] LDR_WDATA,
    output logic                  LDR_GNT,
    output logic                  LDR_RVALID,
    output logic [DATA_WIDTH-1:0] LDR_RDATA,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [DATA_WIDTH-1:0] RAM_WDATA,
    output logic                  RAM_WE,
    input  logic [DATA_WIDTH-1:0] RAM_Q
);

    owner_e owner_q, owner_d;
    logic   limit_reached;
    logic   cnt_load, cnt_incr, cnt_clear;
    logic   tie_to_ldr;

    // ------------------------------------------------------------------
    // Tie-break from idle
    // ------------------------------------------------------------------
`ifdef DATA_MEM_ARB_RR_EN
    port_e rr_q;  // last port served

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rr_q <= PORT_CORE;
        end else if (CORE_GNT) begin
            rr_q <= PORT_CORE;
        end else if (LDR_GNT) begin
            rr_q <= PORT_LDR;
        end
    end

    assign tie_to_ldr = (rr_q == PORT_CORE);
`else
    assign tie_to_ldr = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Owner FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        CORE_GNT  = 1'b0;
        LDR_GNT   = 1'b0;
        owner_d   = OWN_NONE;
        cnt_load  = 1'b0;
        cnt_incr  = 1'b0;
        cnt_clear = 1'b0;

        case (owner_q)
            OWN_CORE: begin
                // Owner keeps the RAM unless the other side waits and the
                // burst limit is used up.
                if (CORE_REQ && (!LDR_REQ || !limit_reached)) begin
                    CORE_GNT = 1'b1;
                end else if (LDR_REQ) begin
                    LDR_GNT = 1'b1;
                end
            end
            OWN_LDR: begin
                if (LDR_REQ && (!CORE_REQ || !limit_reached)) begin
                    LDR_GNT = 1'b1;
                end else if (CORE_REQ) begin
                    CORE_GNT = 1'b1;
                end
            end
            default: begin
                if (CORE_REQ && LDR_REQ) begin
                    LDR_GNT  = tie_to_ldr;
                    CORE_GNT = !tie_to_ldr;
                end else begin
                    CORE_GNT = CORE_REQ;
                    LDR_GNT  = LDR_REQ;
                end
            end
        endcase

        if (CORE_GNT) begin
            owner_d = OWN_CORE;
        end else if (LDR_GNT) begin
            owner_d = OWN_LDR;
        end

        // Same owner again extends the burst; any change starts a new one.
        if (owner_d == OWN_NONE) begin
            cnt_clear = 1'b1;
        end else if (owner_d == owner_q) begin
            cnt_incr = 1'b1;
        end else begin
            cnt_load = 1'b1;
        end
    end

    arb_burst_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_cnt (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .load_one      (cnt_load),
        .incr          (cnt_incr),
        .clear         (cnt_clear),
        .limit_reached (limit_reached)
    );

    assign CORE_STALL = CORE_REQ & ~CORE_GNT;

    // ------------------------------------------------------------------
    // RAM request mux
    // ------------------------------------------------------------------
    always_comb begin
        RAM_ADDR  = '0;
        RAM_WDATA = '0;
        RAM_WE    = 1'b0;
        if (CORE_GNT) begin
            RAM_ADDR  = CORE_ADDR;
            RAM_WDATA = CORE_WDATA;
            RAM_WE    = CORE_WE;
        end else if (LDR_GNT) begin
            RAM_ADDR  = LDR_ADDR;
            RAM_WDATA = LDR_WDATA;
            RAM_WE    = LDR_WE;
        end
    end

    // ------------------------------------------------------------------
    // Read return: tag the issuing port, steer RAM_Q back next cycle.
    // RDATA shows RAM_Q live in the valid cycle and holds it afterwards.
    // ------------------------------------------------------------------
    logic                  rd_vld_q;
    port_e                 rd_tag_q;
    logic [DATA_WIDTH-1:0] core_hold_q, ldr_hold_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_vld_q <= 1'b0;
            rd_tag_q <= PORT_CORE;
        end else begin
            rd_vld_q <= (CORE_GNT & ~CORE_WE) | (LDR_GNT & ~LDR_WE);
            rd_tag_q <= LDR_GNT ? PORT_LDR : PORT_CORE;
        end
    end

    assign CORE_RVALID = rd_vld_q & (rd_tag_q == PORT_CORE);
    assign LDR_RVALID  = rd_vld_q & (rd_tag_q == PORT_LDR);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            core_hold_q <= '0;
            ldr_hold_q  <= '0;
        end else begin
            if (CORE_RVALID) core_hold_q <= RAM_Q;
            if (LDR_RVALID)  ldr_hold_q  <= RAM_Q;
        end
    end

    assign CORE_RDATA = CORE_RVALID ? RAM_Q : core_hold_q;
    assign LDR_RDATA  = LDR_RVALID  ? RAM_Q : ldr_hold_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Directed scenarios followed by random traffic, checked every cycle against
//   a reference model built from the arbitration rules (streak of grants per
//   port, memory image as an array). A RAM stub answers the DUT's RAM port.
module tb_data_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int MB = 4;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          CORE_REQ, CORE_WE, LDR_REQ, LDR_WE;
    logic [AW-1:0] CORE_ADDR, LDR_ADDR, RAM_ADDR;
    logic [DW-1:0] CORE_WDATA, LDR_WDATA, RAM_WDATA;
    logic          CORE_GNT, CORE_STALL, CORE_RVALID, LDR_GNT, LDR_RVALID, RAM_WE;
    logic [DW-1:0] CORE_RDATA, LDR_RDATA;
    logic [DW-1:0] RAM_Q;

    data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .CORE_REQ(CORE_REQ), .CORE_WE(CORE_WE), .CORE_ADDR(CORE_ADDR),
        .CORE_WDATA(CORE_WDATA), .CORE_GNT(CORE_GNT), .CORE_STALL(CORE_STALL),
        .CORE_RVALID(CORE_RVALID), .CORE_RDATA(CORE_RDATA),
        .LDR_REQ(LDR_REQ), .LDR_WE(LDR_WE), .LDR_ADDR(LDR_ADDR),
        .LDR_WDATA(LDR_WDATA), .LDR_GNT(LDR_GNT),
        .LDR_RVALID(LDR_RVALID), .LDR_RDATA(LDR_RDATA),
        .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_WE(RAM_WE), .RAM_Q(RAM_Q)
    );

    always #5 CLK = ~CLK;

    // Single-port synchronous RAM stub
    logic [DW-1:0] ram [0:1023];
    always @(posedge CLK) begin
        if (RAM_WE) ram[RAM_ADDR] <= RAM_WDATA;
        RAM_Q <= ram[RAM_ADDR];
    end

    // ---------------- reference model ----------------
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mmem [0:1023];
    int          s_port;       // 1 = core, 2 = loader
    int          s_len;        // consecutive grants to s_port, 0 = idle
    int          last_srv;     // last port served
    bit          pv;           // read return pending
    int          pport;
    logic [31:0] pdata;
    logic [31:0] hold_c, hold_l;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mgrant(input bit cr, input bit lr);
        int tie;
`ifdef DATA_MEM_ARB_RR_EN
        tie = (last_srv == 1) ? 2 : 1;
`else
        tie = 1;
`endif
        if (cr && lr) begin
            if (s_len == 0) return tie;
            if (s_len < MB) return s_port;
            return (s_port == 1) ? 2 : 1;
        end
        if (cr) return 1;
        if (lr) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        pv = 0; pport = 0; pdata = '0;
        s_port = 0; s_len = 0; last_srv = 1;
        hold_c = '0; hold_l = '0;
    endtask

    // Reset in the middle of the current cycle (before the next rising edge).
    task automatic do_reset();
        #1;
        RESET_N = 1'b0;
        CORE_REQ = 0; LDR_REQ = 0; CORE_WE = 0; LDR_WE = 0;
        #1;
        model_reset();
        chk("rst_core_gnt", 32'(CORE_GNT), 0);
        chk("rst_ldr_gnt", 32'(LDR_GNT), 0);
        chk("rst_core_rvalid", 32'(CORE_RVALID), 0);
        chk("rst_ldr_rvalid", 32'(LDR_RVALID), 0);
        chk("rst_core_rdata", CORE_RDATA, 0);
        chk("rst_ldr_rdata", LDR_RDATA, 0);
        chk("rst_ram_we", 32'(RAM_WE), 0);
        chk("rst_ram_addr", 32'(RAM_ADDR), 0);
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic cycle(input bit cr, input bit cw, input int ca, input logic [31:0] cd,
                         input bit lr, input bit lw, input int la, input logic [31:0] ld);
        int          g;
        bit          gw;
        int          ga;
        logic [31:0] gd;
        @(negedge CLK);
        CORE_REQ = cr; CORE_WE = cw; CORE_ADDR = AW'(ca); CORE_WDATA = cd;
        LDR_REQ = lr; LDR_WE = lw; LDR_ADDR = AW'(la); LDR_WDATA = ld;
        #1;
        // return from last cycle's read
        if (pv && pport == 1) hold_c = pdata;
        if (pv && pport == 2) hold_l = pdata;
        chk("core_rvalid", 32'(CORE_RVALID), 32'(pv && pport == 1));
        chk("ldr_rvalid", 32'(LDR_RVALID), 32'(pv && pport == 2));
        chk("core_rdata", CORE_RDATA, hold_c);
        chk("ldr_rdata", LDR_RDATA, hold_l);
        // this cycle's grant
        g  = mgrant(cr, lr);
        gw = (g == 1) ? cw : (g == 2) ? lw : 1'b0;
        ga = (g == 1) ? ca : (g == 2) ? la : 0;
        gd = (g == 1) ? cd : ld;
        chk("core_gnt", 32'(CORE_GNT), 32'(g == 1));
        chk("ldr_gnt", 32'(LDR_GNT), 32'(g == 2));
        chk("core_stall", 32'(CORE_STALL), 32'(cr && g != 1));
        chk("ram_we", 32'(RAM_WE), 32'(gw));
        chk("ram_addr", 32'(RAM_ADDR), 32'(ga));
        if (gw) chk("ram_wdata", RAM_WDATA, gd);
        // advance model state
        pv = (g != 0) && !gw;
        pport = g;
        pdata = mmem[ga];
        if (gw) mmem[ga] = gd;
        if (g == 0) s_len = 0;
        else if (g == s_port && s_len > 0) s_len = (s_len < MB) ? s_len + 1 : MB;
        else begin s_port = g; s_len = 1; end
        if (g != 0) last_srv = g;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        RESET_N = 1'b0;
        CORE_REQ = 0; CORE_WE = 0; CORE_ADDR = '0; CORE_WDATA = '0;
        LDR_REQ = 0; LDR_WE = 0; LDR_ADDR = '0; LDR_WDATA = '0;
        for (int i = 0; i < 1024; i++) begin
            ram[i]  = $urandom;
            mmem[i] = ram[i];
        end
        ram[16] = 32'hDEADBEEF; mmem[16] = 32'hDEADBEEF;
        do_reset();

        // 1: core read of 0x010
        cycle(1, 0, 16, 0, 0, 0, 0, 0);
        idle();
        chk("s1_core_rdata_hold", CORE_RDATA, 32'hDEADBEEF);

        // 2: continuous contention, bursts of MB each
        for (int i = 0; i < 4 * MB; i++)
            cycle(1, 0, $urandom_range(0, 31), 0, 1, 0, $urandom_range(0, 31), 0);
        idle();
        idle();

        // 3: tie from idle after a core grant
        cycle(1, 0, 5, 0, 0, 0, 0, 0);
        idle();
        cycle(1, 0, 6, 0, 1, 0, 7, 0);
        idle();

        // 4: loader write then core read of the same word
        cycle(0, 0, 0, 0, 1, 1, 0, 32'h0000_0013);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("s4_core_rdata", CORE_RDATA, 32'h0000_0013);

        // 6: interleaved reads on alternate cycles
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 1, 0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 1, 0, 2, 0);
        end
        idle();

        // 5: reset while a core read is outstanding
        cycle(1, 0, 3, 0, 0, 0, 0, 0);
        do_reset();
        idle();
        for (int i = 0; i < MB + 2; i++)
            cycle(1, 0, 8, 0, 1, 0, 9, 0);
        idle();

        // random traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
